// File: rtl/vid_timing_pkg.sv
// Shared types and helpers for the video timing measurement block.
//   axis_state_e : per-axis FSM state (IDLE, SYNC, BACK, ACTIVE, FRONT)
//   sat_inc      : increment that sticks at a caller-supplied maximum
package vid_timing_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_BACK,
        ST_ACTIVE,
        ST_FRONT
    } axis_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/vid_axis_measure.sv
// One measurement axis: sync/back/active/front FSM, four saturating counters
// and the registered result set with its one-cycle strobe.
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   tick_i               advance enable (pixel tick or line tick)
//   edge_i               sync leading edge on this tick; closes the unit
//   sync_i               normalized sync level on this tick
//   active_i             "de" for this tick
//   strobe_o             one-cycle pulse, results below just updated
//   total_o, sync_len_o, active_o, front_o   results of the last closed unit
//
// State table
//   state     | meaning
//   IDLE      | unarmed, waiting for the first sync edge
//   SYNC      | inside the sync pulse
//   BACK      | after sync, no de yet
//   ACTIVE    | de seen and currently high
//   FRONT     | de has dropped, counting front porch
module vid_axis_measure
    import vid_timing_pkg::*;
#(
    parameter int NBITS   = 16,
    // When set, active_i describes the unit that ends at this tick (vertical
    // axis: "the line just closed had DE"), so on an edge it is folded into
    // the closing result rather than the new unit.
    parameter bit DE_LAGS = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tick_i,
    input  logic             edge_i,
    input  logic             sync_i,
    input  logic             active_i,
    output logic             strobe_o,
    output logic [NBITS-1:0] total_o,
    output logic [NBITS-1:0] sync_len_o,
    output logic [NBITS-1:0] active_o,
    output logic [NBITS-1:0] front_o
);

    typedef logic [NBITS-1:0] cnt_t;

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << NBITS) - 64'd1);

    function automatic cnt_t inc(input cnt_t v);
        return cnt_t'(sat_inc(32'(v), CNT_MAX));
    endfunction

    axis_state_e state_q, state_d, state_nxt;
    cnt_t        total_q, total_d;
    cnt_t        sync_q, sync_d;
    cnt_t        act_q, act_d;
    cnt_t        front_q, front_d;
    cnt_t        act_step, front_step;
    logic        strobe_q, strobe_d;
    cnt_t        out_total_q, out_total_d;
    cnt_t        out_sync_q, out_sync_d;
    cnt_t        out_act_q, out_act_d;
    cnt_t        out_front_q, out_front_d;

    always_comb begin
        case (state_q)
            ST_SYNC:            state_nxt = sync_i ? ST_SYNC : (active_i ? ST_ACTIVE : ST_BACK);
            ST_BACK:            state_nxt = active_i ? ST_ACTIVE : ST_BACK;
            ST_ACTIVE, ST_FRONT: state_nxt = active_i ? ST_ACTIVE : ST_FRONT;
            default:            state_nxt = ST_IDLE;
        endcase

        // A tick is attributed to the state it leads into; re-entering ACTIVE
        // from FRONT discards the porch seen so far.
        act_step = active_i ? inc(act_q) : act_q;
        if (state_nxt == ST_FRONT) begin
            front_step = inc(front_q);
        end else if (state_q == ST_FRONT) begin
            front_step = '0;
        end else begin
            front_step = front_q;
        end

        state_d     = state_q;
        total_d     = total_q;
        sync_d      = sync_q;
        act_d       = act_q;
        front_d     = front_q;
        strobe_d    = 1'b0;
        out_total_d = out_total_q;
        out_sync_d  = out_sync_q;
        out_act_d   = out_act_q;
        out_front_d = out_front_q;

        if (tick_i && edge_i) begin
            // First edge after reset only arms the axis.
            if (state_q != ST_IDLE) begin
                strobe_d    = 1'b1;
                out_total_d = total_q;
                out_sync_d  = sync_q;
                out_act_d   = DE_LAGS ? act_step : act_q;
                out_front_d = DE_LAGS ? front_step : front_q;
            end
            state_d = ST_SYNC;
            total_d = cnt_t'(1);
            sync_d  = cnt_t'(1);
            act_d   = (!DE_LAGS && active_i) ? cnt_t'(1) : '0;
            front_d = '0;
        end else if (tick_i && state_q != ST_IDLE) begin
            state_d = state_nxt;
            total_d = inc(total_q);
            if (state_nxt == ST_SYNC) begin
                sync_d = inc(sync_q);
            end
            act_d   = act_step;
            front_d = front_step;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            total_q     <= '0;
            sync_q      <= '0;
            act_q       <= '0;
            front_q     <= '0;
            strobe_q    <= 1'b0;
            out_total_q <= '0;
            out_sync_q  <= '0;
            out_act_q   <= '0;
            out_front_q <= '0;
        end else begin
            state_q     <= state_d;
            total_q     <= total_d;
            sync_q      <= sync_d;
            act_q       <= act_d;
            front_q     <= front_d;
            strobe_q    <= strobe_d;
            out_total_q <= out_total_d;
            out_sync_q  <= out_sync_d;
            out_act_q   <= out_act_d;
            out_front_q <= out_front_d;
        end
    end

    assign strobe_o   = strobe_q;
    assign total_o    = out_total_q;
    assign sync_len_o = out_sync_q;
    assign active_o   = out_act_q;
    assign front_o    = out_front_q;

endmodule

// File: rtl/vid_timing_measure.sv
// Raw video sync timing measurement in the pixel clock domain.
// Ports:
//   i_clk, i_reset_n       pixel clock, async active-low reset
//   i_pix_valid            pixel enable; inputs sampled only when high
//   i_hsync, i_vsync, i_de sync inputs (polarity set by HS_POL/VS_POL) and DE
//   o_hv + o_htotal/o_hsync/o_hactive/o_hfront   per-line results and strobe
//   o_vv + o_vtotal/o_vsync/o_vactive/o_vfront   per-frame results and strobe
module vid_timing_measure
    import vid_timing_pkg::*;
#(
    parameter int   NBITS  = 16,
    parameter logic HS_POL = 1'b1,
    parameter logic VS_POL = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_pix_valid,
    input  logic             i_hsync,
    input  logic             i_vsync,
    input  logic             i_de,
    output logic             o_hv,
    output logic [NBITS-1:0] o_htotal,
    output logic [NBITS-1:0] o_hsync,
    output logic [NBITS-1:0] o_hactive,
    output logic [NBITS-1:0] o_hfront,
    output logic             o_vv,
    output logic [NBITS-1:0] o_vtotal,
    output logic [NBITS-1:0] o_vsync,
    output logic [NBITS-1:0] o_vactive,
    output logic [NBITS-1:0] o_vfront
);

    // Reset asserts asynchronously and is released on the clock.
    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    logic hs, vs;
    logic hs_prev_q, vs_line_q, line_de_q;
    logic h_edge, v_edge;

    assign hs = (i_hsync == HS_POL);
    assign vs = (i_vsync == VS_POL);

    // The vertical axis runs on line ticks: vsync is compared against its
    // value at the previous line start.
    assign h_edge = i_pix_valid & hs & ~hs_prev_q;
    assign v_edge = h_edge & vs & ~vs_line_q;

    always_ff @(posedge i_clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            hs_prev_q <= 1'b0;
            vs_line_q <= 1'b0;
            line_de_q <= 1'b0;
        end else if (i_pix_valid) begin
            hs_prev_q <= hs;
            if (h_edge) begin
                vs_line_q <= vs;
                // The edge pixel already belongs to the new line.
                line_de_q <= i_de;
            end else if (i_de) begin
                line_de_q <= 1'b1;
            end
        end
    end

    vid_axis_measure #(
        .NBITS   (NBITS),
        .DE_LAGS (1'b0)
    ) u_h_axis (
        .clk_i      (i_clk),
        .rst_ni     (rst_n_int),
        .tick_i     (i_pix_valid),
        .edge_i     (h_edge),
        .sync_i     (hs),
        .active_i   (i_de),
        .strobe_o   (o_hv),
        .total_o    (o_htotal),
        .sync_len_o (o_hsync),
        .active_o   (o_hactive),
        .front_o    (o_hfront)
    );

    vid_axis_measure #(
        .NBITS   (NBITS),
        .DE_LAGS (1'b1)
    ) u_v_axis (
        .clk_i      (i_clk),
        .rst_ni     (rst_n_int),
        .tick_i     (h_edge),
        .edge_i     (v_edge),
        .sync_i     (vs),
        .active_i   (line_de_q),
        .strobe_o   (o_vv),
        .total_o    (o_vtotal),
        .sync_len_o (o_vsync),
        .active_o   (o_vactive),
        .front_o    (o_vfront)
    );

endmodule

// File: tb/tb_vid_timing_measure.sv
// Directed bench for vid_timing_measure: three instances share one stimulus
// (default, inverted sync polarity, 8-bit counters).
module tb_vid_timing_measure;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, pv, hs, vs, de;

    logic        hv, vv;
    logic [15:0] htot, hsyn, hact, hfr, vtot, vsyn, vact, vfr;
    logic        hv_i, vv_i;
    logic [15:0] htot_i, hsyn_i, hact_i, hfr_i, vtot_i, vsyn_i, vact_i, vfr_i;
    logic        hv_8, vv_8;
    logic [7:0]  htot_8, hsyn_8, hact_8, hfr_8, vtot_8, vsyn_8, vact_8, vfr_8;

    vid_timing_measure #(.NBITS(16), .HS_POL(1'b1), .VS_POL(1'b1)) u_dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_pix_valid(pv), .i_hsync(hs), .i_vsync(vs), .i_de(de),
        .o_hv(hv), .o_htotal(htot), .o_hsync(hsyn), .o_hactive(hact), .o_hfront(hfr),
        .o_vv(vv), .o_vtotal(vtot), .o_vsync(vsyn), .o_vactive(vact), .o_vfront(vfr)
    );

    vid_timing_measure #(.NBITS(16), .HS_POL(1'b0), .VS_POL(1'b0)) u_dut_inv (
        .i_clk(clk), .i_reset_n(rst_n), .i_pix_valid(pv), .i_hsync(~hs), .i_vsync(~vs), .i_de(de),
        .o_hv(hv_i), .o_htotal(htot_i), .o_hsync(hsyn_i), .o_hactive(hact_i), .o_hfront(hfr_i),
        .o_vv(vv_i), .o_vtotal(vtot_i), .o_vsync(vsyn_i), .o_vactive(vact_i), .o_vfront(vfr_i)
    );

    vid_timing_measure #(.NBITS(8), .HS_POL(1'b1), .VS_POL(1'b1)) u_dut_n8 (
        .i_clk(clk), .i_reset_n(rst_n), .i_pix_valid(pv), .i_hsync(hs), .i_vsync(vs), .i_de(de),
        .o_hv(hv_8), .o_htotal(htot_8), .o_hsync(hsyn_8), .o_hactive(hact_8), .o_hfront(hfr_8),
        .o_vv(vv_8), .o_vtotal(vtot_8), .o_vsync(vsyn_8), .o_vactive(vact_8), .o_vfront(vfr_8)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int          h_target = 0;
    int          cyc = 0;
    int          hv_cnt, vv_cnt, edges_h, edges_v, first_hv_edges, first_vv_edges;
    int          last_hv_cyc, prev_hv_cyc;
    logic        prev_hs_m, prev_vs_m;
    logic [63:0] cap_h, cap_v, cap_h_i, cap_v_i;
    logic [31:0] cap_h8, cap_v8;
    int          hv_cnt_i, hv_cnt_8;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            hv_cnt <= 0; vv_cnt <= 0; hv_cnt_i <= 0; hv_cnt_8 <= 0;
            edges_h <= 0; edges_v <= 0; first_hv_edges <= -1; first_vv_edges <= -1;
            last_hv_cyc <= 0; prev_hv_cyc <= 0; prev_hs_m <= 1'b0; prev_vs_m <= 1'b0;
            cap_h <= '0; cap_v <= '0; cap_h_i <= '0; cap_v_i <= '0; cap_h8 <= '0; cap_v8 <= '0;
        end else begin
            if (hv) begin
                if (hv_cnt == h_target) cap_h <= {htot, hsyn, hact, hfr};
                if (hv_cnt == 0) first_hv_edges <= edges_h;
                hv_cnt      <= hv_cnt + 1;
                prev_hv_cyc <= last_hv_cyc;
                last_hv_cyc <= cyc;
            end
            if (vv) begin
                cap_v <= {vtot, vsyn, vact, vfr};
                if (vv_cnt == 0) first_vv_edges <= edges_v;
                vv_cnt <= vv_cnt + 1;
            end
            if (hv_i) begin
                if (hv_cnt_i == h_target) cap_h_i <= {htot_i, hsyn_i, hact_i, hfr_i};
                hv_cnt_i <= hv_cnt_i + 1;
            end
            if (vv_i) cap_v_i <= {vtot_i, vsyn_i, vact_i, vfr_i};
            if (hv_8) begin
                if (hv_cnt_8 == h_target) cap_h8 <= {htot_8, hsyn_8, hact_8, hfr_8};
                hv_cnt_8 <= hv_cnt_8 + 1;
            end
            if (vv_8) cap_v8 <= {vtot_8, vsyn_8, vact_8, vfr_8};
            if (pv) begin
                if (hs && !prev_hs_m) edges_h <= edges_h + 1;
                if (vs && !prev_vs_m) edges_v <= edges_v + 1;
                prev_hs_m <= hs;
                prev_vs_m <= vs;
            end
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        string name;
        int htot, hsw, hbp, hact;
        int vtot, vsw, vbp, vact;
        int frames, tog, blank, rst_line, target;
        int e_ht, e_hs, e_ha, e_hf;
        int e_vt, e_vs, e_va, e_vf;
        int e_hvn, e_vvn, e_space;
    } vec_t;

    vec_t vecs[7];
    logic any_out;

    function automatic int sat8(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    function automatic logic [63:0] pack16(input int a, input int b, input int c, input int d);
        return {16'(a), 16'(b), 16'(c), 16'(d)};
    endfunction

    function automatic logic [63:0] pack8(input int a, input int b, input int c, input int d);
        return {32'd0, 8'(sat8(a)), 8'(sat8(b)), 8'(sat8(c)), 8'(sat8(d))};
    endfunction

    task automatic drive(input int tg, input logic h, input logic v, input logic d);
        if (tg != 0) begin
            pv = 1'b0;
            hs = 1'($urandom_range(0, 1));
            vs = 1'($urandom_range(0, 1));
            de = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        pv = 1'b1; hs = h; vs = v; de = d;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; pv = 1'b0; hs = 1'b0; vs = 1'b0; de = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic run(input vec_t v);
        int   g;
        logic lact, pde;
        for (int f = 0; f < v.frames; f++) begin
            for (int l = 0; l < v.vtot; l++) begin
                g    = f * v.vtot + l;
                lact = (l >= v.vsw + v.vbp) && (l < v.vsw + v.vbp + v.vact) && (g != v.blank);
                for (int p = 0; p < v.htot; p++) begin
                    if (g == v.rst_line && p == v.htot / 2) begin
                        rst_n = 1'b0;
                        #1;
                        any_out = |{hv, vv, htot, hsyn, hact, hfr, vtot, vsyn, vact, vfr,
                                    hv_i, vv_i, htot_i, hsyn_i, hact_i, hfr_i, vtot_i, vsyn_i, vact_i, vfr_i,
                                    hv_8, vv_8, htot_8, hsyn_8, hact_8, hfr_8, vtot_8, vsyn_8, vact_8, vfr_8};
                        check("rst_outputs_zero", 64'(any_out), 64'd0);
                    end
                    if (g == v.rst_line && p == v.htot / 2 + 3) rst_n = 1'b1;
                    pde = lact && (p >= v.hsw + v.hbp) && (p < v.hsw + v.hbp + v.hact);
                    drive(v.tog, 1'(p < v.hsw), 1'(l < v.vsw), pde);
                end
            end
        end
        // Leading edge of the next frame closes the last line and frame.
        drive(v.tog, 1'b1, 1'b1, 1'b0);
        pv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{"vga_h",     800, 96, 48, 640,   6, 2,  1,   2, 2, 0, -1, -1,   9,
                    800, 96, 640, 16,    6, 2,   2,  1,   12, 2, 800};
        vecs[1] = '{"vga_v",      16,  2,  2,  10, 525, 2, 33, 480, 2, 0, -1, -1, 625,
                     16,  2,  10,  2,  525, 2, 480, 10, 1050, 2,  16};
        vecs[2] = '{"small",      40,  4,  4,  28,  10, 2,  2,   5, 2, 0, -1, -1,  14,
                     40,  4,  28,  4,   10, 2,   5,  1,   20, 2,  40};
        vecs[3] = '{"small_tog",  40,  4,  4,  28,  10, 2,  2,   5, 2, 1, -1, -1,  14,
                     40,  4,  28,  4,   10, 2,   5,  1,   20, 2,  80};
        vecs[4] = '{"long_line", 300, 10, 10, 200,   4, 1,  1,   1, 1, 0, -1, -1,   2,
                    300, 10, 200, 80,    4, 1,   1,  1,    4, 1, 300};
        vecs[5] = '{"no_de",      40,  4,  4,  28,  10, 2,  2,   5, 2, 0, 15, -1,  15,
                     40,  4,   0,  0,   10, 2,   4,  1,   20, 2,  40};
        vecs[6] = '{"reset_mid",  40,  4,  4,  28,  10, 2,  2,   5, 3, 0, -1,  3,  10,
                     40,  4,  28,  4,   10, 2,   5,  1,   26, 2,  40};

        // Hand-written: latency, one-cycle strobe, hold while pv is low.
        do_reset();
        check("reset_hv_low", 64'(hv), 64'd0);
        check("reset_htotal_zero", 64'(htot), 64'd0);
        drive(0, 1'b1, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b0, 1'b1);
        drive(0, 1'b0, 1'b0, 1'b1);
        drive(0, 1'b0, 1'b0, 1'b1);
        drive(0, 1'b0, 1'b0, 1'b0);
        check("no_strobe_on_arm", 64'(hv_cnt), 64'd0);
        drive(0, 1'b1, 1'b0, 1'b0);
        check("latency_strobe", 64'(hv), 64'd1);
        check("latency_values", {htot, hsyn, hact, hfr}, pack16(6, 1, 3, 1));
        pv = 1'b0; hs = 1'b1; de = 1'b1;
        @(posedge clk); #1;
        check("strobe_one_cycle", 64'(hv), 64'd0);
        repeat (5) begin
            hs = ~hs;
            @(posedge clk); #1;
        end
        check("hold_pv_low", {47'd0, hv, htot}, 64'd6);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            h_target = vecs[i].target;
            run(vecs[i]);
            check({vecs[i].name, "_hv_count"}, 64'(hv_cnt), 64'(vecs[i].e_hvn));
            check({vecs[i].name, "_vv_count"}, 64'(vv_cnt), 64'(vecs[i].e_vvn));
            check({vecs[i].name, "_hv_first_edge"}, 64'(first_hv_edges), 64'd2);
            check({vecs[i].name, "_vv_first_edge"}, 64'(first_vv_edges), 64'd2);
            check({vecs[i].name, "_h"}, cap_h,
                  pack16(vecs[i].e_ht, vecs[i].e_hs, vecs[i].e_ha, vecs[i].e_hf));
            check({vecs[i].name, "_v"}, cap_v,
                  pack16(vecs[i].e_vt, vecs[i].e_vs, vecs[i].e_va, vecs[i].e_vf));
            check({vecs[i].name, "_h_inv"}, cap_h_i,
                  pack16(vecs[i].e_ht, vecs[i].e_hs, vecs[i].e_ha, vecs[i].e_hf));
            check({vecs[i].name, "_v_inv"}, cap_v_i,
                  pack16(vecs[i].e_vt, vecs[i].e_vs, vecs[i].e_va, vecs[i].e_vf));
            check({vecs[i].name, "_h_n8"}, 64'(cap_h8),
                  pack8(vecs[i].e_ht, vecs[i].e_hs, vecs[i].e_ha, vecs[i].e_hf));
            check({vecs[i].name, "_v_n8"}, 64'(cap_v8),
                  pack8(vecs[i].e_vt, vecs[i].e_vs, vecs[i].e_va, vecs[i].e_vf));
            check({vecs[i].name, "_hv_spacing"}, 64'(last_hv_cyc - prev_hv_cyc), 64'(vecs[i].e_space));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
